// File: rtl/seq_pkg.sv
// Shared types and encodings for the multi-cycle instruction sequencer:
// state enum, opcode values, ALU operation codes and writeback source select.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_TRAP      = 3'd6
    } state_t;

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_SUB = 6'b000001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;

    localparam logic M2R_ALU = 1'b0;
    localparam logic M2R_MEM = 1'b1;

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode classifier: legality, memory/load/branch class and
// the ALU operation the execute step should request.
module opcode_decode
    import seq_pkg::*;
(
    input  logic [5:0] opcode_i,
    output logic       legal_o,
    output logic       is_mem_o,
    output logic       is_load_o,
    output logic       is_branch_o,
    output logic [1:0] alu_op_o
);

    always_comb begin
        legal_o     = 1'b0;
        is_mem_o    = 1'b0;
        is_load_o   = 1'b0;
        is_branch_o = 1'b0;
        alu_op_o    = ALU_ADD;
        case (opcode_i)
            OP_ADD: legal_o = 1'b1;
            OP_SUB: begin
                legal_o  = 1'b1;
                alu_op_o = ALU_SUB;
            end
            OP_LW: begin
                legal_o   = 1'b1;
                is_mem_o  = 1'b1;
                is_load_o = 1'b1;
            end
            OP_SW: begin
                legal_o  = 1'b1;
                is_mem_o = 1'b1;
            end
            OP_BEQ: begin
                legal_o     = 1'b1;
                is_branch_o = 1'b1;
                alu_op_o    = ALU_SUB;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback control FSM for a single-port
// memory datapath. Optional memory-wait timeout enabled by SEQ_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | stopped at an instruction boundary, waiting for run
// FETCH     | instruction read from PC, held until mem_ready
// DECODE    | classify latched opcode; illegal goes to TRAP
// EXECUTE   | ALU step; BEQ resolves and retires here
// MEM       | data read (LW) or write (SW), held until mem_ready
// WRITEBACK | one-cycle register-file write, retires ADD/SUB/LW
// TRAP      | sticky fault, no strobes until rst
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int RET_W          = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata,
    input  logic             zero,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ir_write,
    output logic             mem_iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic [1:0]       alu_op,
    output logic [2:0]       state,
    output logic             trap,
    output logic [RET_W-1:0] retired
);

    state_t             state_q, state_d, boundary;
    logic [5:0]         opcode_q, opcode_d;
    logic               trap_q, trap_d;
    logic [RET_W-1:0]   retired_q, retired_d;
    logic               retire;
    logic               timeout_hit;
    logic               dec_legal, dec_is_mem, dec_is_load, dec_is_branch;
    logic [1:0]         dec_alu_op;
    logic               unused_rdata;

    assign unused_rdata = ^mem_rdata[25:0];

    opcode_decode u_decode (
        .opcode_i    (opcode_q),
        .legal_o     (dec_legal),
        .is_mem_o    (dec_is_mem),
        .is_load_o   (dec_is_load),
        .is_branch_o (dec_is_branch),
        .alu_op_o    (dec_alu_op)
    );

    // Where a completing instruction goes: next fetch, or park if run dropped.
    assign boundary = run ? ST_FETCH : ST_IDLE;

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        retire     = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        mem_iord   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = M2R_ALU;
        alu_op     = ALU_ADD;
        case (state_q)
            ST_IDLE: if (run) state_d = ST_FETCH;
            ST_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    opcode_d = mem_rdata[31:26];
                    state_d  = ST_DECODE;
                end else if (timeout_hit) begin
                    state_d = ST_TRAP;
                end
            end
            ST_DECODE: state_d = dec_legal ? ST_EXECUTE : ST_TRAP;
            ST_EXECUTE: begin
                alu_op = dec_alu_op;
                if (dec_is_branch) begin
                    pc_write = zero;
                    pc_src   = 1'b1;
                    retire   = 1'b1;
                    state_d  = boundary;
                end else if (dec_is_mem) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_MEM: begin
                mem_iord  = 1'b1;
                mem_read  = dec_is_load;
                mem_write = !dec_is_load;
                if (mem_ready) begin
                    if (dec_is_load) begin
                        state_d = ST_WRITEBACK;
                    end else begin
                        retire  = 1'b1;
                        state_d = boundary;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_TRAP;
                end
            end
            ST_WRITEBACK: begin
                reg_write  = 1'b1;
                mem_to_reg = dec_is_load ? M2R_MEM : M2R_ALU;
                retire     = 1'b1;
                state_d    = boundary;
            end
            ST_TRAP: ;
            default: state_d = ST_IDLE;
        endcase
    end

    assign trap_d    = trap_q | (state_d == ST_TRAP);
    assign retired_d = retired_q + RET_W'(retire);

`ifdef SEQ_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             waiting;

    // Down-counter reloads on FETCH/MEM entry; terminal count on a stalled cycle traps.
    assign waiting     = (state_q == ST_FETCH || state_q == ST_MEM) && !mem_ready;
    assign timeout_hit = waiting && (wait_cnt_q == '0);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if ((state_d == ST_FETCH || state_d == ST_MEM) && state_d != state_q) begin
            wait_cnt_d = CNT_W'(TIMEOUT_CYCLES - 1);
        end else if (waiting) begin
            wait_cnt_d = wait_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) wait_cnt_q <= '0;
        else     wait_cnt_q <= wait_cnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            opcode_q  <= '0;
            trap_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            trap_q    <= trap_d;
            retired_q <= retired_d;
        end
    end

    assign state   = state_q;
    assign trap    = trap_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: random instruction stream with a
// reactive memory model, plus reset, timeout and illegal-opcode scenarios.
module tb_instr_sequencer;
    import seq_pkg::*;

    localparam int RET_W  = 16;
    localparam int TMO    = 16;
    localparam int N_RAND = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run_m = 1'b0, stop_r = 1'b0, drv_en = 1'b0;
    logic d_ready = 1'b0, man_ready = 1'b0;
    logic [31:0] d_rdata = '0, man_rdata = '0;
    logic zero = 1'b0;
    logic run, mem_ready;
    logic [31:0] mem_rdata;

    logic pc_write, pc_src, ir_write, mem_iord, mem_read, mem_write, reg_write, mem_to_reg;
    logic [1:0] alu_op;
    logic [2:0] state;
    logic trap;
    logic [RET_W-1:0] retired;

    assign run       = run_m && !(drv_en && stop_r);
    assign mem_ready = drv_en ? d_ready : man_ready;
    assign mem_rdata = drv_en ? d_rdata : man_rdata;

    always #5 clk = ~clk;

    instr_sequencer #(.RET_W(RET_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .run(run), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .zero(zero), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .mem_iord(mem_iord), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
        .state(state), .trap(trap), .retired(retired)
    );

    typedef struct { logic [5:0] op; int fw; int mw; logic z; } stim_t;
    typedef struct { int kind; logic m2r; logic pcw; int cyc; int idx; } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    stim_t cur;
    int total = 0, bad = 0;
    int cyc = 0, wcnt = 0, kind, n_total;
    logic cyc_en = 1'b0;
    exp_t e;

    task automatic chk(input string nm, input longint act, input longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    function automatic logic [7:0] strobes();
        return {pc_write, pc_src, ir_write, mem_iord, mem_read, mem_write, reg_write, mem_to_reg};
    endfunction

    // Memory model: answers fetch/data requests after the per-instruction wait counts.
    always begin
        @(posedge clk); #1;
        if (drv_en) begin
            d_ready = 1'b0;
            d_rdata = $urandom;
            if (mem_read && !mem_iord) begin
                if (stim_q.size() != 0) begin
                    if (wcnt < stim_q[0].fw) wcnt++;
                    else begin
                        cur     = stim_q.pop_front();
                        d_ready = 1'b1;
                        d_rdata = {cur.op, 26'($urandom)};
                        wcnt    = 0;
                        if (stim_q.size() == 0) stop_r = 1'b1;
                    end
                end
            end else if (mem_iord && (mem_read || mem_write)) begin
                if (wcnt < cur.mw) wcnt++;
                else begin
                    d_ready = 1'b1;
                    wcnt    = 0;
                end
            end else begin
                d_ready = 1'($urandom);
            end
            zero = cur.z;
        end
    end

    // Monitor: every completion event pops one expected record.
    always @(negedge clk) begin
        if (cyc_en && state != ST_IDLE) cyc++;
        if (drv_en && state == ST_EXECUTE)
            chk("alu_op", alu_op, (cur.op == OP_SUB || cur.op == OP_BEQ) ? 1 : 0);
        if (reg_write || (mem_write && mem_ready) || pc_src) begin
            kind = reg_write ? 0 : (pc_src ? 2 : 1);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_completion: kind %0d at cycle %0d, none expected", kind, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("kind", kind, e.kind);
                chk("mem_to_reg", mem_to_reg, e.m2r);
                chk("pc_write", pc_write, e.pcw);
                chk("completion_cycle", cyc, e.cyc);
                chk("retired_before", retired, e.idx);
            end
        end
    end

    initial begin
        logic [5:0] ops [5];
        stim_t s;
        exp_t  x;
        int cum, lat, n;
        ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_LW; ops[3] = OP_SW; ops[4] = OP_BEQ;

        stim_q.push_back('{OP_ADD, 0, 0, 1'b0});
        stim_q.push_back('{OP_LW,  0, 3, 1'b0});
        stim_q.push_back('{OP_BEQ, 0, 0, 1'b1});
        stim_q.push_back('{OP_BEQ, 0, 0, 1'b0});
        for (int i = 0; i < N_RAND; i++) begin
            s.op = ops[$urandom_range(0, 4)];
            s.fw = $urandom_range(0, 3);
            s.mw = $urandom_range(0, 3);
            s.z  = 1'($urandom);
            stim_q.push_back(s);
        end
        n_total = stim_q.size();
        cum = 0;
        for (int i = 0; i < n_total; i++) begin
            s = stim_q[i];
            case (s.op)
                OP_LW:   begin lat = 5 + s.fw + s.mw; x.kind = 0; end
                OP_SW:   begin lat = 4 + s.fw + s.mw; x.kind = 1; end
                OP_BEQ:  begin lat = 3 + s.fw;        x.kind = 2; end
                default: begin lat = 4 + s.fw;        x.kind = 0; end
            endcase
            cum  += lat;
            x.m2r = (s.op == OP_LW);
            x.pcw = (s.op == OP_BEQ) && s.z;
            x.cyc = cum;
            x.idx = i;
            exp_q.push_back(x);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", state, ST_IDLE);
        chk("reset_trap", trap, 0);
        chk("reset_retired", retired, 0);
        chk("reset_strobes", strobes(), 0);
        chk("reset_alu_op", alu_op, 0);

        @(posedge clk); #1;
        drv_en = 1'b1; cyc_en = 1'b1; rst = 1'b0; run_m = 1'b1;
        for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(posedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL completion_timeout: got %0d pending expected 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stop_at_boundary_state", state, ST_IDLE);
        chk("retired_total", retired, n_total);

        // Reset while fetch is stalled.
        @(posedge clk); #1;
        drv_en = 1'b0; cyc_en = 1'b0; man_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("stall_state", state, ST_FETCH);
        chk("stall_mem_read", mem_read, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_fetch_state", state, ST_IDLE);
        chk("rst_fetch_mem_read", mem_read, 0);
        chk("rst_fetch_retired", retired, 0);

        // Memory never answers the fetch.
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk);
        n = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (mem_read) n++;
        end
`ifdef SEQ_TIMEOUT_EN
        chk("timeout_wait_cycles", n, TMO);
        chk("timeout_trap", trap, 1);
        chk("timeout_state", state, ST_TRAP);
`else
        chk("no_timeout_wait_cycles", n, 100);
        chk("no_timeout_trap", trap, 0);
        chk("no_timeout_state", state, ST_FETCH);
`endif

        // Illegal opcode 011111 traps after decode and holds.
        @(posedge clk); #1;
        rst = 1'b1; run_m = 1'b0; man_ready = 1'b1;
        man_rdata = {6'b011111, 26'h3ff_ffff};
        @(posedge clk); #1;
        rst = 1'b0; run_m = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("illegal_state", state, ST_TRAP);
        for (int t = 0; t < 20; t++) begin
            chk("trap_hold", {trap, strobes()}, {1'b1, 8'h00});
            @(negedge clk);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("trap_cleared", trap, 0);
        chk("trap_cleared_state", state, ST_IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle instruction sequencer that steps the single-port-memory datapath through fetch, decode, execute, memory and writeback. It decodes the 6-bit opcode latched from the instruction word and drives the datapath control strobes: register write, memory read/write and ALU operation. It sits between the instruction/data memory handshake and the register file/ALU, replacing static per-opcode control with a cycle-sequenced one.

## Interface

- RET_W, 16, width of retired-instruction counter
- TIMEOUT_CYCLES, 16, memory-wait limit (used only with SEQ_TIMEOUT_EN)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  level; high lets sequencer leave IDLE / start next instruction
- mem_ready  in  1  memory completes current read/write this cycle
- mem_rdata  in  32  memory read data; opcode = bits [31:26] during fetch
- zero  in  1  ALU zero flag, sampled in EXECUTE for BEQ
- pc_write  out  1  update PC this cycle
- pc_src  out  1  0 = PC+4, 1 = branch target
- ir_write  out  1  latch instruction register
- mem_iord  out  1  0 = instruction address (PC), 1 = data address (ALU result)
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_write  out  1  register-file write strobe
- mem_to_reg  out  1  writeback source: 1 = memory data, 0 = ALU
- alu_op  out  2  00 add, 01 sub
- state  out  3  current state encoding (debug)
- trap  out  1  sticky illegal-opcode / timeout flag
- retired  out  RET_W  count of completed instructions

## Operation

- Opcodes: 000000 ADD, 000001 SUB, 100011 LW, 101011 SW, 000100 BEQ; all others illegal.
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
- IDLE: all strobes 0; run=1 -> FETCH.
- FETCH: mem_read=1, mem_iord=0 held until mem_ready. In the mem_ready cycle: ir_write=1, pc_write=1, pc_src=0, opcode register loaded from mem_rdata[31:26]; -> DECODE.
- DECODE: one cycle; illegal opcode -> TRAP; else -> EXECUTE.
- EXECUTE: alu_op = 01 for SUB/BEQ, else 00. ADD/SUB -> WRITEBACK; LW/SW -> MEM; BEQ: pc_write=zero, pc_src=1, retire, -> FETCH if run else IDLE.
- MEM: mem_iord=1, mem_read=1 (LW) or mem_write=1 (SW), held until mem_ready. SW retires on mem_ready -> FETCH/IDLE; LW -> WRITEBACK.
- WRITEBACK: reg_write=1 for exactly one cycle, mem_to_reg=1 only for LW; retire; -> FETCH if run else IDLE.
- run dropped mid-instruction: current instruction completes; stop at instruction boundary.
- TRAP: trap=1, all strobes 0, held until rst.
- retired increments by 1 per completed instruction, wraps modulo 2^RET_W.

## Timing

- Strobes are combinational from registered state, opcode register, mem_ready and zero; state, opcode, trap and retired are registered.
- Zero-wait memory latency: ADD/SUB 4 cycles, LW 5, SW 4, BEQ 3; each mem_ready=0 cycle in FETCH/MEM adds one.
- Reset: next edge state=IDLE, opcode=0, trap=0, retired=0; all strobes 0, alu_op=00. Reset mid-FETCH/MEM drops the request immediately with no completion.
- mem_ready outside FETCH/MEM is ignored.

## Configuration

- SEQ_TIMEOUT_EN defined: wait counter clears on FETCH/MEM entry and counts consecutive mem_ready=0 cycles; when it reaches TIMEOUT_CYCLES -> TRAP (no completion, no retire).
- Undefined: no counter; FETCH/MEM wait indefinitely; TIMEOUT_CYCLES unused.

## Structure

- Package seq_pkg: state enum, opcode localparams, alu_op encodings, mem_to_reg encoding.
- Sub-module opcode_decode: combinational opcode -> {legal, is_mem, is_load, is_branch, alu_op}; the FSM is the top.

## Test plan

- rst, run=1, zero-wait memory, ADD word 0x00000000 -> states FETCH,DECODE,EXECUTE,WRITEBACK; reg_write one cycle with mem_to_reg=0; retired=1 after 4 cycles.
- LW (opcode 100011), mem_ready delayed 3 cycles in MEM -> mem_read and mem_iord=1 held 4 cycles; reg_write with mem_to_reg=1; total 8 cycles.
- BEQ with zero=1, then zero=0 -> pc_write and pc_src=1 in EXECUTE only in first; retired=2 after 6 cycles.
- Opcode 011111 -> TRAP after DECODE, trap=1, no strobes for 20 cycles; rst clears trap.
- rst asserted in FETCH wait -> next cycle state=IDLE, mem_read=0, retired=0.
- With SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, mem_ready held 0 in FETCH -> TRAP after 16 wait cycles; without macro, still FETCH after 100 cycles.
